// File: rtl/mfda_pad_sequencer.sv
// Pneumatic pad sequencer: vents released valves, dwells while stepping the
// three-phase peristaltic pumps, vents the pumps, then reports completion.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// VENT  | pulsing pad_flush_ctrl on valves that were just released
// RUN   | dwell timer running, pumps stepping until strokes are done
// PVENT | pulsing pad_flush_pump with the last pump drive
// DONE  | one-cycle completion pulse
module mfda_pad_sequencer #(
    parameter int N_CTRL       = 13,
    parameter int N_PUMP       = 2,
    parameter int DWELL_W      = 16,
    parameter int STROKE_W     = 12,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [N_CTRL-1:0]     cmd_valves,
    input  logic [N_PUMP-1:0]     cmd_pump_en,
    input  logic [STROKE_W-1:0]   cmd_strokes,
    input  logic [DWELL_W-1:0]    cmd_dwell,
    input  logic [7:0]            cmd_step_div,
    input  logic                  abort,
    output logic [N_CTRL-1:0]     pad_ctrl,
    output logic [3*N_PUMP-1:0]   pad_pump,
    output logic [N_CTRL-1:0]     pad_flush_ctrl,
    output logic [3*N_PUMP-1:0]   pad_flush_pump,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_VENT, S_RUN, S_PVENT, S_DONE} state_t;
    state_t state, state_n;

    logic [N_PUMP-1:0]   cfg_pump_en, cfg_pump_en_n;
    logic [STROKE_W-1:0] cfg_strokes, cfg_strokes_n;
    logic [DWELL_W-1:0]  cfg_dwell, cfg_dwell_n;
    logic [7:0]          cfg_step_div, cfg_step_div_n;
    logic [FW-1:0]       flush_cnt, flush_cnt_n;
    logic [DWELL_W-1:0]  dwell_cnt, dwell_cnt_n;
    logic                dwell_met, dwell_met_n;
    logic [7:0]          div_cnt, div_cnt_n;
    logic [2:0]          phase, phase_n;
    logic [STROKE_W-1:0] strokes_done, strokes_done_n;

    logic                cmd_ready_n, busy_n, done_n, aborted_n;
    logic [N_CTRL-1:0]   pad_ctrl_n, pad_flush_ctrl_n, release_mask;
    logic [3*N_PUMP-1:0] pad_pump_n, pad_flush_pump_n;

    logic [DWELL_W-1:0]  dwell_m1;
    logic [STROKE_W-1:0] strokes_nx;
    logic [2:0]          phase_nx;
    logic                dwell_ok, pump_cfg, pumping, step, wrap, strokes_ok;

    function automatic logic [3*N_PUMP-1:0] pump_drive(input logic [2:0] ph,
                                                       input logic [N_PUMP-1:0] en);
        logic [2:0]          pat;
        logic [3*N_PUMP-1:0] d;
        case (ph)
            3'd0:    pat = 3'b100;
            3'd1:    pat = 3'b110;
            3'd2:    pat = 3'b010;
            3'd3:    pat = 3'b011;
            3'd4:    pat = 3'b001;
            3'd5:    pat = 3'b101;
            default: pat = 3'b000;
        endcase
        d = '0;
        for (int k = 0; k < N_PUMP; k++)
            if (en[k]) d[3*k +: 3] = pat;
        return d;
    endfunction

    // A zero dwell still spends one cycle in RUN; dwell_met keeps the
    // condition once reached so a long pump run cannot lose it on wrap.
    assign dwell_m1     = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
    assign dwell_ok     = dwell_met || (dwell_cnt >= dwell_m1);
    assign pump_cfg     = (cfg_strokes != '0) && (cfg_pump_en != '0);
    assign pumping      = pump_cfg && (strokes_done != cfg_strokes);
    assign step         = pumping && (div_cnt == cfg_step_div);
    assign wrap         = step && (phase == 3'd5);
    assign phase_nx     = !step ? phase : (wrap ? 3'd0 : phase + 3'd1);
    assign strokes_nx   = strokes_done + STROKE_W'(wrap);
    assign strokes_ok   = !pump_cfg || (strokes_nx == cfg_strokes);
    assign release_mask = pad_ctrl & ~cmd_valves;

    always_comb begin
        state_n          = state;
        cfg_pump_en_n    = cfg_pump_en;
        cfg_strokes_n    = cfg_strokes;
        cfg_dwell_n      = cfg_dwell;
        cfg_step_div_n   = cfg_step_div;
        flush_cnt_n      = flush_cnt;
        dwell_cnt_n      = '0;
        dwell_met_n      = 1'b0;
        div_cnt_n        = '0;
        phase_n          = '0;
        strokes_done_n   = '0;
        cmd_ready_n      = cmd_ready;
        busy_n           = busy;
        done_n           = done;
        aborted_n        = aborted;
        pad_ctrl_n       = pad_ctrl;
        pad_flush_ctrl_n = pad_flush_ctrl;
        pad_pump_n       = pad_pump;
        pad_flush_pump_n = pad_flush_pump;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cfg_pump_en_n  = cmd_pump_en;
                    cfg_strokes_n  = cmd_strokes;
                    cfg_dwell_n    = cmd_dwell;
                    cfg_step_div_n = cmd_step_div;
                    pad_ctrl_n     = cmd_valves;
                    cmd_ready_n    = 1'b0;
                    busy_n         = 1'b1;
                    aborted_n      = 1'b0;
                    if (release_mask != '0) begin
                        state_n          = S_VENT;
                        pad_flush_ctrl_n = release_mask;
                        flush_cnt_n      = FLUSH_LAST;
                    end else begin
                        state_n    = S_RUN;
                        pad_pump_n = (cmd_strokes != '0) ? pump_drive(3'd0, cmd_pump_en) : '0;
                    end
                end
            end
            S_VENT: begin
                if (abort) begin
                    state_n          = S_PVENT;
                    aborted_n        = 1'b1;
                    pad_flush_ctrl_n = '0;
                    pad_flush_pump_n = pad_pump;
                    pad_pump_n       = '0;
                    flush_cnt_n      = (pad_pump != '0) ? FLUSH_LAST : '0;
                end else if (flush_cnt == '0) begin
                    state_n          = S_RUN;
                    pad_flush_ctrl_n = '0;
                    pad_pump_n       = pump_cfg ? pump_drive(3'd0, cfg_pump_en) : '0;
                end else begin
                    flush_cnt_n = flush_cnt - FW'(1);
                end
            end
            S_RUN: begin
                dwell_cnt_n    = dwell_cnt + DWELL_W'(1);
                dwell_met_n    = dwell_ok;
                div_cnt_n      = (step || !pumping) ? '0 : div_cnt + 8'd1;
                phase_n        = phase_nx;
                strokes_done_n = strokes_nx;
                if (abort || (dwell_ok && strokes_ok)) begin
                    state_n          = S_PVENT;
                    aborted_n        = abort;
                    pad_flush_pump_n = pad_pump;
                    pad_pump_n       = '0;
                    flush_cnt_n      = (pad_pump != '0) ? FLUSH_LAST : '0;
                end else begin
                    pad_pump_n = (pumping && (strokes_nx != cfg_strokes))
                               ? pump_drive(phase_nx, cfg_pump_en) : '0;
                end
            end
            S_PVENT: begin
                if (flush_cnt == '0) begin
                    state_n          = S_DONE;
                    pad_flush_pump_n = '0;
                    done_n           = 1'b1;
                end else begin
                    flush_cnt_n = flush_cnt - FW'(1);
                end
            end
            S_DONE: begin
                state_n     = S_IDLE;
                done_n      = 1'b0;
                aborted_n   = 1'b0;
                busy_n      = 1'b0;
                cmd_ready_n = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cfg_pump_en    <= '0;
            cfg_strokes    <= '0;
            cfg_dwell      <= '0;
            cfg_step_div   <= '0;
            flush_cnt      <= '0;
            dwell_cnt      <= '0;
            dwell_met      <= 1'b0;
            div_cnt        <= '0;
            phase          <= '0;
            strokes_done   <= '0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            pad_ctrl       <= '0;
            pad_flush_ctrl <= '0;
            pad_pump       <= '0;
            pad_flush_pump <= '0;
        end else begin
            state          <= state_n;
            cfg_pump_en    <= cfg_pump_en_n;
            cfg_strokes    <= cfg_strokes_n;
            cfg_dwell      <= cfg_dwell_n;
            cfg_step_div   <= cfg_step_div_n;
            flush_cnt      <= flush_cnt_n;
            dwell_cnt      <= dwell_cnt_n;
            dwell_met      <= dwell_met_n;
            div_cnt        <= div_cnt_n;
            phase          <= phase_n;
            strokes_done   <= strokes_done_n;
            cmd_ready      <= cmd_ready_n;
            busy           <= busy_n;
            done           <= done_n;
            aborted        <= aborted_n;
            pad_ctrl       <= pad_ctrl_n;
            pad_flush_ctrl <= pad_flush_ctrl_n;
            pad_pump       <= pad_pump_n;
            pad_flush_pump <= pad_flush_pump_n;
        end
    end

endmodule

// File: tb/tb_mfda_pad_sequencer.sv
// Directed bench for mfda_pad_sequencer: vent, pump stepping, dwell, abort,
// back-to-back handshake and mid-operation reset, with hand-derived timing.
module tb_mfda_pad_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid, cmd_ready, abort, busy, done, aborted;
    logic [12:0] cmd_valves, pad_ctrl, pad_flush_ctrl;
    logic [1:0]  cmd_pump_en;
    logic [11:0] cmd_strokes;
    logic [15:0] cmd_dwell;
    logic [7:0]  cmd_step_div;
    logic [5:0]  pad_pump, pad_flush_pump;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] pat [6];

    always #5 clk = ~clk;

    mfda_pad_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_valves(cmd_valves), .cmd_pump_en(cmd_pump_en), .cmd_strokes(cmd_strokes),
        .cmd_dwell(cmd_dwell), .cmd_step_div(cmd_step_div), .abort(abort),
        .pad_ctrl(pad_ctrl), .pad_pump(pad_pump), .pad_flush_ctrl(pad_flush_ctrl),
        .pad_flush_pump(pad_flush_pump), .busy(busy), .done(done), .aborted(aborted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [12:0] v, input logic [1:0] en, input logic [11:0] st,
                        input logic [15:0] dw, input logic [7:0] dv);
        chk("ready_before_send", cmd_ready, 1);
        cmd_valves = v; cmd_pump_en = en; cmd_strokes = st; cmd_dwell = dw; cmd_step_div = dv;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Pad and vent on the same bit would fight each other pneumatically.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ctrl_overlap", 32'(pad_ctrl & pad_flush_ctrl), 0);
            chk("pump_overlap", 32'(pad_pump & pad_flush_pump), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, vc, bad;
        pat[0] = 3'b100; pat[1] = 3'b110; pat[2] = 3'b010;
        pat[3] = 3'b011; pat[4] = 3'b001; pat[5] = 3'b101;
        cmd_valid = 0; abort = 0; cmd_valves = 0; cmd_pump_en = 0;
        cmd_strokes = 0; cmd_dwell = 0; cmd_step_div = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_ctrl", pad_ctrl, 0);
        chk("rst_pump", pad_pump, 0);
        chk("rst_fctrl", pad_flush_ctrl, 0);
        chk("rst_fpump", pad_flush_pump, 0);

        // plain dwell, no vent, no pumping
        send(13'h5, 2'b00, 12'd0, 16'd3, 8'd0);
        chk("t1_ctrl", pad_ctrl, 13'h5);
        chk("t1_no_vent", pad_flush_ctrl, 0);
        chk("t1_busy", busy, 1);
        chk("t1_ready_low", cmd_ready, 0);
        wait_done(n);
        chk("t1_latency", n, 4);
        chk("t1_aborted", aborted, 0);
        chk("t1_ctrl_hold", pad_ctrl, 13'h5);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_ready_back", cmd_ready, 1);
        chk("t1_busy_low", busy, 0);

        // releasing bit 0 vents it for FLUSH_CYCLES
        send(13'h4, 2'b00, 12'd0, 16'd1, 8'd0);
        vc = 0; bad = 0; n = 0;
        while (done !== 1'b1 && n < 100) begin
            if (pad_flush_ctrl == 13'h1) vc++;
            if (pad_ctrl != 13'h4) bad++;
            tick();
            n++;
        end
        chk("t2_vent_len", vc, 4);
        chk("t2_ctrl_hold", bad, 0);
        chk("t2_latency", n, 6);
        chk("t2_vent_off", pad_flush_ctrl, 0);
        tick();

        // pump 0, two strokes, phase held two cycles
        send(13'h4, 2'b01, 12'd2, 16'd1, 8'd1);
        for (int i = 0; i < 24; i++) begin
            chk("t3_pump_seq", pad_pump, {3'b000, pat[(i / 2) % 6]});
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t3_pump_off", pad_pump, 0);
            chk("t3_pump_vent", pad_flush_pump, 6'b000101);
            chk("t3_not_done", done, 0);
            tick();
        end
        chk("t3_done", done, 1);
        chk("t3_aborted", aborted, 0);
        chk("t3_vent_off", pad_flush_pump, 0);
        tick();

        // dwell outlasts the strokes
        send(13'h4, 2'b01, 12'd2, 16'd40, 8'd1);
        for (int i = 0; i < 40; i++) begin
            chk("t4_pump_seq", pad_pump, (i < 24) ? {3'b000, pat[(i / 2) % 6]} : 6'b0);
            tick();
        end
        chk("t4_pvent_zero", pad_flush_pump, 0);
        chk("t4_pvent_busy", busy, 1);
        chk("t4_not_done", done, 0);
        tick();
        chk("t4_done", done, 1);
        tick();

        // abort in the third phase, both pumps
        send(13'h4, 2'b11, 12'd2, 16'd1, 8'd0);
        chk("t5_ph0", pad_pump, 6'b100100);
        tick();
        chk("t5_ph1", pad_pump, 6'b110110);
        tick();
        chk("t5_ph2", pad_pump, 6'b010010);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_pump_off", pad_pump, 0);
            chk("t5_pump_vent", pad_flush_pump, 6'b010010);
            chk("t5_not_done", done, 0);
            tick();
        end
        chk("t5_done", done, 1);
        chk("t5_aborted", aborted, 1);
        tick();
        chk("t5_aborted_clr", aborted, 0);
        chk("t5_ready", cmd_ready, 1);

        // abort during the ctrl vent cuts it short
        send(13'h0, 2'b00, 12'd0, 16'd5, 8'd0);
        chk("t6_vent0", pad_flush_ctrl, 13'h4);
        chk("t6_ctrl", pad_ctrl, 0);
        tick();
        chk("t6_vent1", pad_flush_ctrl, 13'h4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_vent_cut", pad_flush_ctrl, 0);
        chk("t6_no_pvent", pad_flush_pump, 0);
        chk("t6_not_done", done, 0);
        tick();
        chk("t6_done", done, 1);
        chk("t6_aborted", aborted, 1);
        tick();

        // cmd_valid held high across a busy period
        cmd_valves = 13'h1; cmd_pump_en = 0; cmd_strokes = 0; cmd_dwell = 16'd2; cmd_step_div = 0;
        cmd_valid = 1'b1;
        chk("t7_ready", cmd_ready, 1);
        tick();
        cmd_valves = 13'h2;
        chk("t7_ready_low", cmd_ready, 0);
        chk("t7_ctrl1", pad_ctrl, 13'h1);
        tick(); tick(); tick();
        chk("t7_done", done, 1);
        chk("t7_no_reaccept", pad_ctrl, 13'h1);
        chk("t7_ready_done", cmd_ready, 0);
        tick();
        chk("t7_idle_ready", cmd_ready, 1);
        chk("t7_idle_busy", busy, 0);
        tick();
        cmd_valid = 1'b0;
        chk("t7_second_busy", busy, 1);
        chk("t7_ctrl2", pad_ctrl, 13'h2);
        chk("t7_vent", pad_flush_ctrl, 13'h1);
        wait_done(n);
        chk("t7_latency", n, 7);
        tick();

        // reset mid-pumping clears every pad with no vent
        send(13'h2, 2'b01, 12'd3, 16'd1, 8'd0);
        tick(); tick(); tick();
        chk("t8_pump_ph3", pad_pump, 6'b000011);
        rst = 1'b1;
        tick();
        chk("t8_rst_pump", pad_pump, 0);
        chk("t8_rst_ctrl", pad_ctrl, 0);
        chk("t8_rst_fpump", pad_flush_pump, 0);
        chk("t8_rst_ready", cmd_ready, 1);
        chk("t8_rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("t8_post_fpump", pad_flush_pump, 0);
        chk("t8_post_fctrl", pad_flush_ctrl, 0);
        chk("t8_post_pump", pad_pump, 0);
        chk("t8_post_ready", cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
